// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access size codes,
// controller state encoding, byte-enable patterns and the small address
// helpers used when a request is latched.
package mem_access_unit_pkg;

    // Access size codes carried in op[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte-enable patterns driven toward the data memory
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    // True when the low address bits are not naturally aligned for the size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

    // Low address bits with the misaligned part cleared for the size
    function automatic logic [1:0] align_low(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return {lo[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the request/response signals toward the control FSM and the
// data-memory bus signals. The unit uses the master view; the environment
// (datapath + memory) uses the slave view.
interface mem_access_unit_if;

    // Request from the datapath
    logic        start;
    logic        store;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;

    // Response to the datapath / control FSM
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    // Data memory side
    logic        memwrite;
    logic [3:0]  BE;
    logic [31:0] mem_wdata;
    logic [31:0] waddr;
    logic [31:0] memdata;

    modport master (
        input  start, store, op, addr, wdata, memdata,
        output rdata, busy, done, err, memwrite, BE, mem_wdata, waddr
    );

    modport slave (
        output start, store, op, addr, wdata, memdata,
        input  rdata, busy, done, err, memwrite, BE, mem_wdata, waddr
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load formatter: picks the addressed byte/half lane out of a
// 32-bit memory word and sign- or zero-extends it according to op.
// Kept separate so a cache read path can reuse the same formatting.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] memdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Lane select followed by sign or zero extension
    always_comb begin
        byte_v = memdata[7:0];
        case (lane)
            2'd0: byte_v = memdata[7:0];
            2'd1: byte_v = memdata[15:8];
            2'd2: byte_v = memdata[23:16];
            2'd3: byte_v = memdata[31:24];
            default: byte_v = memdata[7:0];
        endcase
        half_v = lane[1] ? memdata[31:16] : memdata[15:0];
        byte_s = signed'(byte_v);
        half_s = signed'(half_v);

        result = memdata;
        case (op[1:0])
            SZ_BYTE: result = op[2] ? {24'd0, byte_v} : 32'(byte_s);
            SZ_HALF: result = op[2] ? {16'd0, half_v} : 32'(half_s);
            SZ_WORD: result = memdata;
            default: result = memdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the byte-enabled data memory. Takes one load or
// store per start, drives the memory strobe/enables/address/data for a
// single ACCESS cycle, formats load data into rdata and reports done/err.
//
// Build option: MEM_ALIGN_TRAP_EN
//   defined   - misaligned half/word requests fault.
//   undefined - misaligned low address bits are cleared when the request is
//               latched and the access proceeds.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_BYTES = 8192
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.master  bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q;
    state_t      state_d;

    logic        store_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] req_addr;
    logic [3:0]  store_be;
    logic [31:0] load_result;

    // A request is only looked at while the unit is idle
    assign accept = (state_q == ST_IDLE) && bus.start;

    // Classify the incoming request and form the address to latch
    always_comb begin
        req_fault = (bus.op[1:0] == SZ_RSVD) || (bus.addr >= MEM_LIMIT);
        req_addr  = bus.addr;
`ifdef MEM_ALIGN_TRAP_EN
        if (is_misaligned(bus.op[1:0], bus.addr[1:0])) begin
            req_fault = 1'b1;
        end
`else
        req_addr[1:0] = align_low(bus.op[1:0], bus.addr[1:0]);
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCESS lasts one cycle, DONE/FAULT one cycle each
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = req_fault ? ST_FAULT : ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch, loaded on accept and held for the whole transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            store_q <= bus.store;
            op_q    <= bus.op;
            addr_q  <= req_addr;
            wdata_q <= bus.wdata;
        end
    end

    // Lane select and extension of the word returned by the memory
    mem_access_unit_load_extend u_load_extend (
        .memdata (bus.memdata),
        .lane    (addr_q[1:0]),
        .op      (op_q),
        .result  (load_result)
    );

    // Load result register, updated only by a load in its ACCESS cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if ((state_q == ST_ACCESS) && !store_q) begin
            rdata_q <= load_result;
        end
    end

    // Byte enables for a store, derived from the latched size and address
    always_comb begin
        store_be = BE_NONE;
        case (op_q[1:0])
            SZ_BYTE: store_be = BE_BYTE0 << addr_q[1:0];
            SZ_HALF: store_be = addr_q[1] ? BE_HI_HALF : BE_LO_HALF;
            SZ_WORD: store_be = BE_WORD;
            default: store_be = BE_NONE;
        endcase
    end

    // Status and memory strobe decoded from state; write strobe only in ACCESS
    always_comb begin
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.memwrite = 1'b0;
        bus.BE       = BE_NONE;
        case (state_q)
            ST_ACCESS: begin
                if (store_q) begin
                    bus.memwrite = 1'b1;
                    bus.BE       = store_be;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            ST_FAULT: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
            end
            default: begin
                bus.done = 1'b0;
            end
        endcase
    end

    // Store data goes out unshifted; the memory steers it into the lanes
    assign bus.waddr     = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a directed vector table, hand-written
// multi-cycle sequences (ignored start, async reset mid-store) and random
// transactions checked against a byte-array memory model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(8192)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed data memory image, little-endian lanes
    logic [7:0] mem [0:8191];

    // Combinational read word at the word-aligned DUT address
    always_comb begin
        bus.memdata = {mem[{bus.waddr[12:2], 2'b11}], mem[{bus.waddr[12:2], 2'b10}],
                       mem[{bus.waddr[12:2], 2'b01}], mem[{bus.waddr[12:2], 2'b00}]};
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_rdata;

    typedef struct {
        string       name;
        bit          st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          fault;
        logic [3:0]  be;
        logic [31:0] waddr;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    function automatic void add(input string nm, input bit st, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit fault, input logic [3:0] be,
                                input logic [31:0] waddr, input logic [31:0] rd);
        vec_t v;
        v.name = nm; v.st = st; v.op = op; v.addr = addr; v.wdata = wdata;
        v.fault = fault; v.be = be; v.waddr = waddr; v.rd = rd;
        vecs.push_back(v);
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
    endtask

    // Effect of a completed store on the memory image
    task automatic mem_store(input logic [31:0] ea, input int n, input logic [31:0] wdata);
        for (int i = 0; i < n; i++) mem[int'(ea) + i] = wdata[8*i +: 8];
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " busy"}, 32'(bus.busy), 32'd0);
        chk({nm, " done"}, 32'(bus.done), 32'd0);
        chk({nm, " err"}, 32'(bus.err), 32'd0);
        chk({nm, " memwrite"}, 32'(bus.memwrite), 32'd0);
        chk({nm, " BE"}, 32'(bus.BE), 32'd0);
        chk({nm, " waddr"}, bus.waddr, 32'd0);
        chk({nm, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({nm, " rdata"}, bus.rdata, 32'd0);
    endtask

    // One transaction from IDLE back to IDLE with cycle-exact checks
    task automatic run_txn(input string nm, input bit st, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit exp_fault, input logic [3:0] exp_be,
                           input logic [31:0] exp_waddr, input logic [31:0] exp_rd);
        logic [31:0] want_rd;
        want_rd = (!exp_fault && !st) ? exp_rd : cur_rdata;
        chk({nm, " idle busy"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.store = st; bus.op = op; bus.addr = addr; bus.wdata = wdata;
        tick();
        bus.start = 1'b0; bus.store = ~st; bus.op = ~op; bus.addr = $urandom; bus.wdata = $urandom;
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        if (exp_fault) begin
            chk({nm, " fault done"}, 32'(bus.done), 32'd1);
            chk({nm, " fault err"}, 32'(bus.err), 32'd1);
            chk({nm, " fault memwrite"}, 32'(bus.memwrite), 32'd0);
            chk({nm, " fault BE"}, 32'(bus.BE), 32'd0);
        end else begin
            chk({nm, " access done"}, 32'(bus.done), 32'd0);
            chk({nm, " access memwrite"}, 32'(bus.memwrite), 32'(st));
            chk({nm, " access BE"}, 32'(bus.BE), 32'(exp_be));
            chk({nm, " access waddr"}, bus.waddr, exp_waddr);
            if (st) chk({nm, " access mem_wdata"}, bus.mem_wdata, wdata);
            tick();
            chk({nm, " done"}, 32'(bus.done), 32'd1);
            chk({nm, " err"}, 32'(bus.err), 32'd0);
            chk({nm, " done memwrite"}, 32'(bus.memwrite), 32'd0);
            chk({nm, " done BE"}, 32'(bus.BE), 32'd0);
            chk({nm, " done busy"}, 32'(bus.busy), 32'd1);
        end
        chk({nm, " rdata"}, bus.rdata, want_rd);
        tick();
        chk({nm, " end done"}, 32'(bus.done), 32'd0);
        chk({nm, " end busy"}, 32'(bus.busy), 32'd0);
        chk({nm, " end rdata"}, bus.rdata, want_rd);
        cur_rdata = want_rd;
    endtask

    // Reference model: expectations derived from the access rules on the byte image
    task automatic rand_txn(input int k);
        bit          st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ea;
        logic [31:0] rd;
        logic [3:0]  be;
        bit          fault;
        int          n;
        longint      v;
        st    = 1'($urandom_range(0, 1));
        op    = 3'($urandom_range(0, 7));
        wdata = $urandom;
        case ($urandom_range(0, 9))
            0:       addr = $urandom;
            1:       addr = 32'(8184 + $urandom_range(0, 15));
            default: addr = 32'($urandom_range(0, 255));
        endcase
        n     = nbytes(op[1:0]);
        fault = (op[1:0] == 2'b11) || (addr >= 32'd8192);
        ea    = addr;
        if ((addr % 32'(n)) != 0) begin
`ifdef MEM_ALIGN_TRAP_EN
            fault = 1'b1;
`else
            ea = addr - (addr % 32'(n));
`endif
        end
        be = 4'b0000;
        rd = 32'd0;
        if (!fault) begin
            if (st) begin
                for (int i = 0; i < n; i++) be[int'(ea[1:0]) + i] = 1'b1;
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v + (longint'(mem[int'(ea) + i]) << (8 * i));
                if (!op[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
        run_txn($sformatf("rnd%0d", k), st, op, addr, wdata, fault, be, ea, rd);
        if (st && !fault) mem_store(ea, n, wdata);
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        bus.start = 1'b0; bus.store = 1'b0; bus.op = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        put_word(32'h20, 32'h8001_1234);
        put_word(32'h200, 32'hCAFE_F00D);
        put_word(32'h1FFC, 32'h7F00_0000);
        cur_rdata = 32'd0;

        // Reset state
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Directed vectors: name, st, op, addr, wdata, fault, BE, waddr, rdata
        add("sw_word",   1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 4'b1111, 32'h10,   32'h0);
        add("sb_13",     1, 3'b000, 32'h13,   32'h123456A5, 0, 4'b1000, 32'h13,   32'h0);
        add("lb_13",     0, 3'b000, 32'h13,   32'h0,        0, 4'b0000, 32'h13,   32'hFFFFFFA5);
        add("lbu_13",    0, 3'b100, 32'h13,   32'h0,        0, 4'b0000, 32'h13,   32'h000000A5);
        add("lh_22",     0, 3'b001, 32'h22,   32'h0,        0, 4'b0000, 32'h22,   32'hFFFF8001);
        add("lhu_20",    0, 3'b101, 32'h20,   32'h0,        0, 4'b0000, 32'h20,   32'h00001234);
        add("lb_21",     0, 3'b000, 32'h21,   32'h0,        0, 4'b0000, 32'h21,   32'h00000012);
        add("lbu_23",    0, 3'b100, 32'h23,   32'h0,        0, 4'b0000, 32'h23,   32'h00000080);
        add("lb_23",     0, 3'b000, 32'h23,   32'h0,        0, 4'b0000, 32'h23,   32'hFFFFFF80);
        add("lw_20",     0, 3'b010, 32'h20,   32'h0,        0, 4'b0000, 32'h20,   32'h80011234);
        add("sh_22",     1, 3'b001, 32'h22,   32'h0000BEEF, 0, 4'b1100, 32'h22,   32'h0);
        add("lw_20b",    0, 3'b010, 32'h20,   32'h0,        0, 4'b0000, 32'h20,   32'hBEEF1234);
        add("lhu_12",    0, 3'b101, 32'h12,   32'h0,        0, 4'b0000, 32'h12,   32'h0000A5AD);
        add("sb_11",     1, 3'b000, 32'h11,   32'hFFFFFFFF, 0, 4'b0010, 32'h11,   32'h0);
        add("lw_10",     0, 3'b010, 32'h10,   32'h0,        0, 4'b0000, 32'h10,   32'hA5ADFFEF);
        add("lw_range",  0, 3'b010, 32'h2000, 32'h0,        1, 4'b0000, 32'h0,    32'h0);
        add("sw_range",  1, 3'b010, 32'h2000, 32'h1,        1, 4'b0000, 32'h0,    32'h0);
        add("ld_rsvd",   0, 3'b011, 32'h10,   32'h0,        1, 4'b0000, 32'h0,    32'h0);
        add("st_rsvd",   1, 3'b111, 32'h10,   32'h5,        1, 4'b0000, 32'h0,    32'h0);
        add("lb_top",    0, 3'b000, 32'h1FFF, 32'h0,        0, 4'b0000, 32'h1FFF, 32'h0000007F);
        add("lw_top",    0, 3'b010, 32'h1FFC, 32'h0,        0, 4'b0000, 32'h1FFC, 32'h7F000000);
        add("lbu_range", 0, 3'b100, 32'h2000, 32'h0,        1, 4'b0000, 32'h0,    32'h0);
`ifdef MEM_ALIGN_TRAP_EN
        add("lw_mis",    0, 3'b010, 32'h201,  32'h0,        1, 4'b0000, 32'h0,    32'h0);
        add("lh_mis",    0, 3'b001, 32'h203,  32'h0,        1, 4'b0000, 32'h0,    32'h0);
        add("sh_mis",    1, 3'b001, 32'h201,  32'h5555,     1, 4'b0000, 32'h0,    32'h0);
        add("lw_200",    0, 3'b010, 32'h200,  32'h0,        0, 4'b0000, 32'h200,  32'hCAFEF00D);
`else
        add("lw_mis",    0, 3'b010, 32'h201,  32'h0,        0, 4'b0000, 32'h200,  32'hCAFEF00D);
        add("lh_mis",    0, 3'b001, 32'h203,  32'h0,        0, 4'b0000, 32'h202,  32'hFFFFCAFE);
        add("sh_mis",    1, 3'b001, 32'h201,  32'h5555,     0, 4'b0011, 32'h200,  32'h0);
        add("lw_200",    0, 3'b010, 32'h200,  32'h0,        0, 4'b0000, 32'h200,  32'hCAFE5555);
`endif

        foreach (vecs[i]) begin
            run_txn(vecs[i].name, vecs[i].st, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                    vecs[i].fault, vecs[i].be, vecs[i].waddr, vecs[i].rd);
            if (vecs[i].st && !vecs[i].fault)
                mem_store(vecs[i].waddr, nbytes(vecs[i].op[1:0]), vecs[i].wdata);
        end

        // start held through ACCESS and DONE must not launch a second access
        ndone = 0;
        bus.start = 1'b1; bus.store = 1'b1; bus.op = 3'b010; bus.addr = 32'h44; bus.wdata = 32'hA1B2C3D4;
        tick();
        bus.store = 1'b0; bus.addr = 32'h80;
        chk("ign access waddr", bus.waddr, 32'h44);
        chk("ign access memwrite", 32'(bus.memwrite), 32'd1);
        if (bus.done) ndone++;
        tick();
        if (bus.done) ndone++;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (bus.done) ndone++;
            chk("ign memwrite idle", 32'(bus.memwrite), 32'd0);
            tick();
        end
        chk("ign done count", 32'(ndone), 32'd1);
        chk("ign waddr kept", bus.waddr, 32'h44);
        chk("ign busy", 32'(bus.busy), 32'd0);
        mem_store(32'h44, 4, 32'hA1B2C3D4);
        run_txn("lw_44", 0, 3'b010, 32'h44, 32'h0, 0, 4'b0000, 32'h44, 32'hA1B2C3D4);

        // Asynchronous reset in the middle of a store ACCESS
        bus.start = 1'b1; bus.store = 1'b1; bus.op = 3'b010; bus.addr = 32'h40; bus.wdata = 32'h11223344;
        tick();
        bus.start = 1'b0;
        chk("rst pre memwrite", 32'(bus.memwrite), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst async memwrite", 32'(bus.memwrite), 32'd0);
        chk("rst async BE", 32'(bus.BE), 32'd0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.done || bus.err) ndone++;
            tick();
        end
        chk("rst no pulse", 32'(ndone), 32'd0);
        check_all_zero("rst after");
        cur_rdata = 32'd0;

        // Random transactions against the memory model
        for (int k = 0; k < 300; k++) rand_txn(k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
